// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter/receiver pair: frame states,
// default line rates and the clocks-per-bit helper.
package uart_pkg;

  localparam int DEFAULT_CLOCK_FREQ = 50_000_000;
  localparam int DEFAULT_BAUD_RATE  = 9600;
  localparam int FRAME_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    RECOVER = 3'd5
  } uart_state_e;

  function automatic int clocks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side byte handshake and status bundle between uart_rx (master)
// and the consuming logic (slave).
interface uart_rx_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  modport master (
    output data, valid, busy, frame_err, overrun, parity_err,
    input  ready
  );

  modport slave (
    input  data, valid, busy, frame_err, overrun, parity_err,
    output ready
  );
endinterface

// File: rtl/uart_sync.sv
// Two-flop synchroniser for asynchronous inputs; flops load rst_val on
// synchronous active-low reset so the output starts at a known level.
module uart_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_p0 <= rst_val;
      sync_p1 <= rst_val;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a valid/ready byte output.
// Define UART_RX_PARITY_EN to add an even-parity bit and parity_err reporting.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ     = DEFAULT_CLOCK_FREQ,
  parameter int BAUD_RATE      = DEFAULT_BAUD_RATE,
  parameter int CLOCKS_PER_BIT = clocks_per_bit(CLOCK_FREQ, BAUD_RATE)
) (
  input logic       clk,
  input logic       rst,
  input logic       rx,
  uart_rx_if.master bus
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam int IDX_W = $clog2(FRAME_DATA_BITS);
  localparam int HALF  = CLOCKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_DATA_BITS - 1);

  logic rx_s;

  uart_sync #(.WIDTH(1)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .rst_val (1'b1),
    .d       (rx),
    .q       (rx_s)
  );

  uart_state_e      state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic [7:0]       shreg;
  logic             shift_en;
  logic             stop_ok;
  logic             stop_bad;
  logic             deliver;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             frame_pulse;
  logic             overrun_pulse;

`ifdef UART_RX_PARITY_EN
  logic par_sample;
  logic par_bit;
  logic par_bad;
  logic parity_pulse;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    idx_next   = idx;
    shift_en   = 1'b0;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_sample = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (!rx_s) state_next = START;
      end
      START: begin
        // Re-check the line half a bit in so glitches are rejected as false starts
        if (cnt == CNT_HALF) begin
          cnt_next   = '0;
          idx_next   = '0;
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_next = '0;
          shift_en = 1'b1;
          if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == CNT_LAST) begin
          cnt_next   = '0;
          par_sample = 1'b1;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            stop_ok    = 1'b1;
            state_next = IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = RECOVER;
          end
        end
      end
      RECOVER: begin
        cnt_next = '0;
        if (rx_s) state_next = IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // LSB arrives first, so bits enter at the MSB and shift down
  always_ff @(posedge clk) begin
    if (shift_en) shreg <= {rx_s, shreg[7:1]};
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (par_sample) par_bit <= rx_s;
  end

  assign par_bad = par_bit ^ (^shreg);
  assign deliver = stop_ok && !par_bad;

  always_ff @(posedge clk) begin
    if (!rst) parity_pulse <= 1'b0;
    else      parity_pulse <= stop_ok && par_bad;
  end

  assign bus.parity_err = parity_pulse;
`else
  assign deliver        = stop_ok;
  assign bus.parity_err = 1'b0;
`endif

  // A same-cycle accept frees the holding register for the new byte
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      frame_pulse   <= 1'b0;
      overrun_pulse <= 1'b0;
    end else begin
      frame_pulse   <= stop_bad;
      overrun_pulse <= 1'b0;
      if (rx_valid && bus.ready) rx_valid <= 1'b0;
      if (deliver) begin
        if (!rx_valid || bus.ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun_pulse <= 1'b1;
        end
      end
    end
  end

  assign bus.data      = rx_data;
  assign bus.valid     = rx_valid;
  assign bus.busy      = (state != IDLE);
  assign bus.frame_err = frame_pulse;
  assign bus.overrun   = overrun_pulse;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver paired with the `uart` transmitter: 8N1 frames in, LSB first, at BAUD_RATE.
- Synchronises the asynchronous `rx` line and detects the start bit.
- Samples each bit at mid-bit and presents the received byte on a valid/ready handshake to the consuming logic.
- Flags framing errors and overruns; parity checking is optional.

Parameters:
- CLOCK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate in bits per second.
- CLOCKS_PER_BIT, CLOCK_FREQ/BAUD_RATE, clock cycles per bit, derived. Must be >= 4.

Ports:
- clk  in  1  system clock; one clock domain, all logic on posedge clk.
- rst  in  1  reset; synchronous and active-low (rst==0 resets on the next posedge clk).
- rx  in  1  asynchronous serial line; idles high.
- data  out  8  received byte; valid only while `valid`==1.
- valid  out  1  byte available; held high until accepted.
- ready  in  1  consumer accepts the byte when valid&&ready at posedge clk.
- busy  out  1  high from start-bit detection until the frame ends (STOP or RECOVER exit).
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- overrun  out  1  one-cycle pulse: a good frame completed while valid was still high.
- parity_err  out  1  one-cycle pulse: parity mismatch; constant 0 unless UART_RX_PARITY_EN.

Behaviour:
- Reset values: data=0, valid=0, busy=0, frame_err=0, overrun=0, parity_err=0, state=IDLE, counters=0.
- Synchroniser registers reset to 1 (line idle).
- `rx` passes through a 2-flop synchroniser; `rx_s` is the synchronised line. Line-to-state latency is 2 cycles.
- Bit counter: counts 0..CLOCKS_PER_BIT-1, width $clog2(CLOCKS_PER_BIT). HALF = CLOCKS_PER_BIT/2 (integer division).
- State IDLE: busy=0.
  - rx_s==0 -> START; counter cleared; busy=1.
- State START:
  - At counter==HALF-1, sample rx_s.
  - Sample 0 -> DATA; counter cleared; bit index=0.
  - Sample 1 -> false start: back to IDLE, busy=0, no flags raised.
- State DATA:
  - At counter==CLOCKS_PER_BIT-1, sample rx_s into the shift register: shift right, new bit in MSB, so LSB is first on the line.
  - After bit index 7 -> STOP, or PARITY when UART_RX_PARITY_EN. Otherwise bit index+1.
- State STOP: at counter==CLOCKS_PER_BIT-1, sample rx_s.
  - Sample 1 and no parity error -> deliver (see below), then IDLE.
  - Sample 1 with parity error -> parity_err pulse, byte discarded, IDLE.
  - Sample 0 -> frame_err pulse, byte discarded, RECOVER.
- State RECOVER: wait until rx_s==1 (break condition), then IDLE; busy=0 on exit.
- Deliver:
  - valid==0: data<=shift register, valid<=1 on the cycle after the stop-bit sample.
  - valid==1 (old byte not yet accepted): old data kept, new byte dropped, overrun pulses for 1 cycle.
- Handshake:
  - valid&&ready at a posedge -> valid<=0 next cycle.
  - data is stable while valid==1.
  - ready is ignored while valid==0.
  - Accept and deliver in the same cycle: the new byte is loaded, valid stays 1, no overrun.
- Sample points: bit n is sampled at HALF-1 + (n+1)*CLOCKS_PER_BIT cycles after `rx_s` falls (n=0..7). The stop bit follows with n=8, or n=9 when parity is enabled.
- Reset mid-frame: all state is abandoned and valid drops. After reset the line must be high before a new start is detected, because IDLE only reacts to rx_s==0 arriving after the synchroniser initialises to 1.
- Encoding: state is 3 bits; illegal encodings -> IDLE.

Optional Feature:
- UART_RX_PARITY_EN defined:
  - Adds state PARITY after DATA, one bit period long, sampled at CLOCKS_PER_BIT-1.
  - Even parity: the XOR of the 8 data bits and the parity bit must be 0.
  - A mismatch is reported at the stop-bit sample through parity_err (see STOP). The byte is not delivered.
  - Frame is 11 bits.
- Undefined:
  - Frame is 10 bits (8N1).
  - parity_err tied 0.
  - PARITY state logic is absent from the RTL.

Decomposition:
- uart_pkg shared with the `uart` transmitter:
  - state enum (IDLE, START, DATA, PARITY, STOP, RECOVER);
  - default CLOCK_FREQ/BAUD_RATE constants;
  - clocks_per_bit function;
  - FRAME_DATA_BITS=8.
- Sub-module uart_sync: parameterised 2-flop synchroniser with reset value input. It can be reused for other async inputs.

Test Plan:
- Bench uses CLOCK_FREQ=16, BAUD_RATE=1 (CLOCKS_PER_BIT=16, HALF=8).
- Loopback: `uart` tx -> rx, send 0xA5, ready=1 -> data=0xA5 with valid high 1 cycle; busy drops; no flags. Repeat for 0x00, 0xFF, 0x01.
- False start: drive rx low 5 cycles, then high -> stays in or returns to IDLE; valid, frame_err and busy end at 0 within 10 cycles.
- Framing error: frame 0x3C with stop bit forced 0, line held low 40 cycles -> frame_err pulse once, valid stays 0. After line high, frame 0x55 -> data=0x55.
- Overrun and handshake:
  - ready=0, send 0x11 then 0x22 -> data=0x11, valid held high, overrun pulses once at the second stop sample.
  - Then ready=1 -> valid drops next cycle.
- Reset mid-frame: assert rst=0 for 2 cycles during DATA bit 3 of 0x96 -> all outputs return to reset values. After line idle, the next frame 0x69 is received correctly.
- Parity (UART_RX_PARITY_EN):
  - 0x07 with parity bit 1 -> delivered.
  - 0x07 with parity bit 0 -> parity_err pulse, valid stays 0.
